// File: rtl/sobel_job_scheduler.sv
// sobel_job_scheduler: queues 3x3 jobs for one Sobel engine, zeroes border pixels, emits tagged results in order.
// Define SOBEL_JOB_SCHED_STATS_EN to add the O_DROP_CNT / O_JOB_CNT counters.
module sobel_job_scheduler #(
  parameter int COL_W    = 10,
  parameter int ROW_W    = 9,
  parameter int MATRIX_W = 64,
  parameter int DEPTH    = 4,
  parameter int H_ACT    = 640,
  parameter int V_ACT    = 480,
  parameter int TIMEOUT  = 32
) (
  input  logic                I_CLK,
  input  logic                I_RST_N,
  input  logic                I_FRAME_START,
  input  logic                I_MATRIX_READY,
  input  logic [ROW_W-1:0]    I_PIXEL_ROW,
  input  logic [COL_W-1:0]    I_PIXEL_COLUMN,
  input  logic [MATRIX_W-1:0] I_PIXEL_MATRIX,
  output logic                O_SOBEL_START,
  output logic [ROW_W-1:0]    O_SOBEL_ROW,
  output logic [COL_W-1:0]    O_SOBEL_COL,
  output logic [MATRIX_W-1:0] O_SOBEL_MATRIX,
  input  logic                I_SOBEL_DONE,
  input  logic [7:0]          I_SOBEL_OUT,
  output logic                O_PIX_VALID,
  output logic [7:0]          O_PIX,
  output logic [ROW_W-1:0]    O_PIX_ROW,
  output logic [COL_W-1:0]    O_PIX_COL,
  output logic                O_BUSY,
  output logic                O_OVERFLOW,
`ifdef SOBEL_JOB_SCHED_STATS_EN
  output logic [15:0]         O_DROP_CNT,
  output logic [15:0]         O_JOB_CNT,
`endif
  output logic                O_TIMEOUT
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);
  localparam int EW = ROW_W + COL_W + MATRIX_W;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, EMIT} state_t;
  state_t state, state_nx;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [TW-1:0] timer;
  logic [7:0] res;
  logic ovf, tmo;
  logic [ROW_W-1:0] head_row;
  logic [COL_W-1:0] head_col;
  logic border, full, pop, wr_en, drop, done_hit, tmo_hit;
  assign {head_row, head_col} = mem[rd_ptr][EW-1 -: ROW_W+COL_W];
  assign border = head_row == '0 || head_row == ROW_W'(V_ACT-1) || head_col == '0 || head_col == COL_W'(H_ACT-1);
  assign full = count == (AW+1)'(DEPTH);
  assign pop = state == IDLE && count != '0 && !I_FRAME_START;
  // a frame start flushes the queue, so the coincident push always lands in slot 0
  assign wr_en = I_MATRIX_READY && (I_FRAME_START || !full || pop);
  assign drop = I_MATRIX_READY && !I_FRAME_START && full && !pop;
  assign done_hit = state == WAIT && I_SOBEL_DONE;
  assign tmo_hit = state == WAIT && !I_SOBEL_DONE && timer == TW'(TIMEOUT-1);
  always_comb begin
    state_nx = state;
    if (state == IDLE && count != '0) state_nx = border ? EMIT : ISSUE;
    else if (state == ISSUE) state_nx = WAIT;
    else if (done_hit || tmo_hit) state_nx = EMIT;
    else if (state == EMIT) state_nx = IDLE;
    if (I_FRAME_START) state_nx = IDLE;
  end
  always_ff @(posedge I_CLK)
    if (wr_en) mem[I_FRAME_START ? AW'(0) : wr_ptr] <= {I_PIXEL_ROW, I_PIXEL_COLUMN, I_PIXEL_MATRIX};
  always_ff @(posedge I_CLK or negedge I_RST_N)
    if (!I_RST_N) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      timer <= '0;
      res <= '0;
      ovf <= 1'b0;
      tmo <= 1'b0;
      O_SOBEL_ROW <= '0;
      O_SOBEL_COL <= '0;
      O_SOBEL_MATRIX <= '0;
    end else begin
      state <= state_nx;
      if (I_FRAME_START) begin
        rd_ptr <= '0;
        wr_ptr <= AW'(I_MATRIX_READY);
        count <= (AW+1)'(I_MATRIX_READY);
        ovf <= 1'b0;
        tmo <= 1'b0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + AW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + (AW+1)'(wr_en) - (AW+1)'(pop);
        if (drop) ovf <= 1'b1;
        if (tmo_hit) tmo <= 1'b1;
      end
      if (pop) {O_SOBEL_ROW, O_SOBEL_COL, O_SOBEL_MATRIX} <= mem[rd_ptr];
      if (pop || tmo_hit) res <= '0;
      else if (done_hit) res <= I_SOBEL_OUT;
      if (state == ISSUE) timer <= '0;
      else if (state == WAIT) timer <= timer + TW'(1);
    end
  assign O_SOBEL_START = state == ISSUE;
  assign O_PIX_VALID = state == EMIT;
  assign O_PIX = O_PIX_VALID ? res : '0;
  assign O_PIX_ROW = O_PIX_VALID ? O_SOBEL_ROW : '0;
  assign O_PIX_COL = O_PIX_VALID ? O_SOBEL_COL : '0;
  assign O_BUSY = count != '0 || state != IDLE;
  assign O_OVERFLOW = ovf;
  assign O_TIMEOUT = tmo;
`ifdef SOBEL_JOB_SCHED_STATS_EN
  always_ff @(posedge I_CLK or negedge I_RST_N)
    if (!I_RST_N) begin
      O_DROP_CNT <= '0;
      O_JOB_CNT <= '0;
    end else if (I_FRAME_START) begin
      O_DROP_CNT <= '0;
      O_JOB_CNT <= '0;
    end else begin
      if (drop && O_DROP_CNT != 16'hFFFF) O_DROP_CNT <= O_DROP_CNT + 16'd1;
      if (O_PIX_VALID && O_JOB_CNT != 16'hFFFF) O_JOB_CNT <= O_JOB_CNT + 16'd1;
    end
`endif
endmodule
